// File: rtl/id_regfile_sext_pkg.sv
// Shared widths and types for the decode-stage register file / immediate block.
package id_regfile_sext_pkg;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned ADDR_W   = 5;
    localparam int unsigned IMM_W    = 16;
    localparam int unsigned NUM_REGS = 2 ** ADDR_W;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] data_t;

endpackage

// File: rtl/sign_extend_unit.sv
// Registered 16->32 sign extension; en=0 holds the previous result.
import id_regfile_sext_pkg::*;

module sign_extend_unit (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [IMM_W-1:0]  imm,
    output logic [DATA_W-1:0] sext_imm
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sext_imm <= '0;
        end else if (en) begin
            sext_imm <= {{(DATA_W - IMM_W){imm[IMM_W-1]}}, imm};
        end
    end

endmodule

// File: rtl/id_regfile_sext.sv
// Decode-stage operands: 32x32 register file with write-first bypass and
// registered read ports, plus registered sign-extended immediate.
import id_regfile_sext_pkg::*;

module id_regfile_sext (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_en,
    input  logic [IMM_W-1:0]  imm,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    output logic [DATA_W-1:0] sext_imm,
    output logic [DATA_W-1:0] sext_imm_sl2
);

    data_t regs [NUM_REGS];
    data_t rd_next1;
    data_t rd_next2;
    logic  wr_hit;

    assign wr_hit = wr_en && (wr_addr != '0);

    // Writes are independent of stall so writeback can drain while decode is held.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_hit) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Write-first: a read of the address being written this edge sees the new data.
    always_comb begin
        rd_next1 = regs[rd_addr1];
        if (wr_hit && (wr_addr == rd_addr1)) begin
            rd_next1 = wr_data;
        end
        if (rd_addr1 == '0) begin
            rd_next1 = '0;
        end
    end

    always_comb begin
        rd_next2 = regs[rd_addr2];
        if (wr_hit && (wr_addr == rd_addr2)) begin
            rd_next2 = wr_data;
        end
        if (rd_addr2 == '0) begin
            rd_next2 = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data1 <= '0;
            rd_data2 <= '0;
        end else if (!stall) begin
            rd_data1 <= rd_next1;
            rd_data2 <= rd_next2;
        end
    end

    sign_extend_unit u_sext (
        .clk      (clk),
        .reset    (reset),
        .en       (!stall),
        .imm      (imm),
        .sext_imm (sext_imm)
    );

    assign sext_imm_sl2 = {sext_imm[DATA_W-3:0], 2'b00};

endmodule

// File: tb/tb_id_regfile_sext.sv
// Self-checking bench for id_regfile_sext: directed cases plus random traffic
// compared against an array-based reference model.
module tb_id_regfile_sext;

    logic        clk;
    logic        reset;
    logic        stall;
    logic [4:0]  rd_addr1;
    logic [4:0]  rd_addr2;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        wr_en;
    logic [15:0] imm;
    logic [31:0] rd_data1;
    logic [31:0] rd_data2;
    logic [31:0] sext_imm;
    logic [31:0] sext_imm_sl2;

    logic [31:0] model [32];
    logic [31:0] exp1;
    logic [31:0] exp2;
    logic [31:0] exp_sext;
    int          n_total;
    int          n_pass;

    id_regfile_sext dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .rd_addr1     (rd_addr1),
        .rd_addr2     (rd_addr2),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .wr_en        (wr_en),
        .imm          (imm),
        .rd_data1     (rd_data1),
        .rd_data2     (rd_data2),
        .sext_imm     (sext_imm),
        .sext_imm_sl2 (sext_imm_sl2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    endtask

    task automatic check_all(input string tag);
        check({tag, ".rd1"}, rd_data1, exp1);
        check({tag, ".rd2"}, rd_data2, exp2);
        check({tag, ".sext"}, sext_imm, exp_sext);
        check({tag, ".sl2"}, sext_imm_sl2, exp_sext * 32'd4);
    endtask

    task automatic clear_model();
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        exp1 = 32'h0;
        exp2 = 32'h0;
        exp_sext = 32'h0;
    endtask

    // One clock: apply the edge to the model, then compare on the falling edge.
    task automatic tick(input string tag);
        int s;
        @(posedge clk);
        if (wr_en && wr_addr != 5'd0) model[wr_addr] = wr_data;
        if (!stall) begin
            exp1 = model[rd_addr1];
            exp2 = model[rd_addr2];
            s = $signed(imm);
            exp_sext = s;
        end
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic drive(input logic st, input logic [4:0] a1, input logic [4:0] a2,
                         input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic [15:0] im);
        stall = st;
        rd_addr1 = a1;
        rd_addr2 = a2;
        wr_en = we;
        wr_addr = wa;
        wr_data = wd;
        imm = im;
    endtask

    initial begin
        n_total = 0;
        n_pass = 0;
        reset = 1'b1;
        drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 16'h0);
        clear_model();
        repeat (2) @(negedge clk);
        check_all("reset_state");
        reset = 1'b0;

        // write/read and r0 rule
        drive(1'b0, 5'd0, 5'd0, 1'b1, 5'd5, 32'hDEADBEEF, 16'h0);
        tick("wr_r5");
        drive(1'b0, 5'd5, 5'd0, 1'b0, 5'd0, 32'h0, 16'h0);
        tick("rd_r5");
        check("rd_r5_const", rd_data1, 32'hDEADBEEF);
        drive(1'b0, 5'd0, 5'd0, 1'b1, 5'd0, 32'h1234, 16'h0);
        tick("wr_r0");
        drive(1'b0, 5'd0, 5'd5, 1'b0, 5'd0, 32'h0, 16'h0);
        tick("rd_r0");
        check("rd_r0_const", rd_data1, 32'h0);

        // simultaneous bypass on both ports
        drive(1'b0, 5'd7, 5'd7, 1'b1, 5'd7, 32'hA5A5A5A5, 16'h0);
        tick("bypass");
        check("bypass1_const", rd_data1, 32'hA5A5A5A5);
        check("bypass2_const", rd_data2, 32'hA5A5A5A5);

        // sign extension boundaries
        drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 16'h7FFF);
        tick("sext_7fff");
        check("sext_7fff_const", sext_imm, 32'h00007FFF);
        check("sl2_7fff_const", sext_imm_sl2, 32'h0001FFFC);
        drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 16'h8000);
        tick("sext_8000");
        check("sext_8000_const", sext_imm, 32'hFFFF8000);
        check("sl2_8000_const", sext_imm_sl2, 32'hFFFE0000);

        // stall holds outputs while the write still lands
        drive(1'b0, 5'd2, 5'd0, 1'b1, 5'd2, 32'h11, 16'h0001);
        tick("stall_setup");
        drive(1'b1, 5'd3, 5'd3, 1'b1, 5'd3, 32'h22, 16'h1234);
        tick("stall_hold");
        check("stall_hold_const", rd_data1, 32'h11);
        drive(1'b0, 5'd3, 5'd0, 1'b0, 5'd0, 32'h0, 16'hF00D);
        tick("stall_release");
        check("stall_release_const", rd_data1, 32'h22);

        // sweep write then read back all registers on both ports
        for (int i = 1; i < 32; i++) begin
            drive(1'b0, 5'd0, 5'd0, 1'b1, 5'(i), 32'(i) * 32'h01010101, 16'(i));
            tick("sweep_wr");
        end
        for (int i = 0; i < 32; i++) begin
            drive(1'b0, 5'(i), 5'(31 - i), 1'b0, 5'd0, 32'h0, 16'(i * 977));
            tick("sweep_rd");
            check("sweep_rd1_const", rd_data1, 32'(i) * 32'h01010101);
        end

        // random traffic
        for (int i = 0; i < 300; i++) begin
            drive(($urandom_range(0, 3) == 0), 5'($urandom_range(0, 31)),
                  5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 31)), $urandom, 16'($urandom));
            if ($urandom_range(0, 3) == 0) rd_addr1 = wr_addr;
            tick("random");
        end

        // asynchronous reset mid-cycle after writes
        drive(1'b0, 5'd9, 5'd10, 1'b1, 5'd9, 32'hCAFEF00D, 16'hFFFF);
        tick("pre_reset");
        #2;
        reset = 1'b1;
        #1;
        clear_model();
        check_all("async_reset");
        @(negedge clk);
        reset = 1'b0;
        for (int i = 1; i < 32; i++) begin
            drive(1'b0, 5'(i), 5'(32 - i), 1'b0, 5'd0, 32'h0, 16'h0);
            tick("post_reset");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
